// File: rtl/mips_fwd_pkg.sv
// Shared types and constants for the register-file forwarding scoreboard.
package mips_fwd_pkg;

    localparam logic [5:0]  OPC_RTYPE = 6'h00;
    localparam int unsigned SEL_RF    = 0;
    // Widest register address the tag can hold; narrower addresses are zero-extended.
    localparam int unsigned TAG_DST_W = 8;

    typedef struct packed {
        logic                 valid;
        logic                 we;
        logic [TAG_DST_W-1:0] dst;
        logic                 is_load;
    } fwd_tag_t;

endpackage

// File: rtl/rf_fwd_port_match.sv
// Priority match of one ID read port against the in-flight destination tags.
module rf_fwd_port_match
    import mips_fwd_pkg::*;
#(
    parameter int unsigned REG_ADDR_W     = 5,
    parameter int unsigned NUM_FWD_STAGES = 3,
    parameter int unsigned LOAD_LAT       = 1,
    localparam int unsigned SEL_W         = $clog2(NUM_FWD_STAGES + 1)
) (
    input  fwd_tag_t [NUM_FWD_STAGES-1:0] tags,
    input  logic [REG_ADDR_W-1:0]         addr,
    input  logic                          used,
    output logic [SEL_W-1:0]              sel,
    output logic                          hazard
);

    logic [TAG_DST_W-1:0] addr_ext;
    logic                 found;

    assign addr_ext = TAG_DST_W'(addr);

    // Youngest stage (lowest index) wins; older matches are masked by 'found'.
    always_comb begin
        sel    = SEL_W'(SEL_RF);
        hazard = 1'b0;
        found  = 1'b0;
        for (int s = 0; s < int'(NUM_FWD_STAGES); s++) begin
            if (!found && used && (addr != '0) && tags[s].valid && tags[s].we &&
                (tags[s].dst == addr_ext)) begin
                found = 1'b1;
                if (tags[s].is_load && (s < int'(LOAD_LAT))) begin
                    hazard = 1'b1;
                end else begin
                    sel = SEL_W'(int'(NUM_FWD_STAGES) - s);
                end
            end
        end
    end

endmodule

// File: rtl/rf_forward_scoreboard.sv
// Forwarding select and load-use stall unit; tracks destination tags from EX to WB.
module rf_forward_scoreboard
    import mips_fwd_pkg::*;
#(
    parameter int unsigned REG_ADDR_W     = 5,
    parameter int unsigned NUM_RD_PORTS   = 2,
    parameter int unsigned NUM_FWD_STAGES = 3,
    parameter int unsigned LOAD_LAT       = 1,
    parameter int unsigned STALL_CNT_W    = 16,
    localparam int unsigned SEL_W         = $clog2(NUM_FWD_STAGES + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               id_valid,
    input  logic [5:0]                         id_opcode,
    input  logic [REG_ADDR_W-1:0]              id_rt,
    input  logic [REG_ADDR_W-1:0]              id_rd,
    input  logic                               id_reg_write,
    input  logic                               id_mem_read,
    input  logic [NUM_RD_PORTS*REG_ADDR_W-1:0] id_src_addr,
    input  logic [NUM_RD_PORTS-1:0]            id_src_used,
    input  logic                               flush,
    input  logic                               ext_stall,
    output logic [NUM_RD_PORTS*SEL_W-1:0]      fwd_sel,
    output logic                               load_use_stall,
    output logic [STALL_CNT_W-1:0]             stall_count
);

    fwd_tag_t [NUM_FWD_STAGES-1:0] tag_q;
    fwd_tag_t                      id_tag;
    logic [REG_ADDR_W-1:0]         id_dst;
    logic [NUM_RD_PORTS-1:0]       hazard;
    logic [STALL_CNT_W-1:0]        stall_cnt_q;

    always_comb begin
        id_dst         = (id_opcode == OPC_RTYPE) ? id_rd : id_rt;
        id_tag         = '0;
        id_tag.valid   = 1'b1;
        id_tag.we      = id_reg_write & (id_dst != '0);
        id_tag.dst     = TAG_DST_W'(id_dst);
        id_tag.is_load = id_mem_read;
    end

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
        rf_fwd_port_match #(
            .REG_ADDR_W     (REG_ADDR_W),
            .NUM_FWD_STAGES (NUM_FWD_STAGES),
            .LOAD_LAT       (LOAD_LAT)
        ) u_match (
            .tags   (tag_q),
            .addr   (id_src_addr[p*REG_ADDR_W +: REG_ADDR_W]),
            .used   (id_src_used[p]),
            .sel    (fwd_sel[p*SEL_W +: SEL_W]),
            .hazard (hazard[p])
        );
    end

    // A flushed ID instruction never stalls, even if it would have hazarded.
    assign load_use_stall = id_valid & ~flush & (|hazard);
    assign stall_count    = stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q       <= '0;
            stall_cnt_q <= '0;
        end else if (!ext_stall) begin
            for (int s = int'(NUM_FWD_STAGES) - 1; s > 0; s--) begin
                tag_q[s] <= tag_q[s-1];
            end
            tag_q[0] <= (!id_valid || flush || load_use_stall) ? '0 : id_tag;
            if (load_use_stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rf_forward_scoreboard.sv
// Directed and randomized checks of rf_forward_scoreboard against an instruction-level model.
module tb_rf_forward_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [5:0] id_opcode;
    logic [4:0] id_rt;
    logic [4:0] id_rd;
    logic       id_reg_write;
    logic       id_mem_read;
    logic [9:0] id_src_addr;
    logic [1:0] id_src_used;
    logic       flush;
    logic       ext_stall;
    logic [3:0] fwd_sel;
    logic       load_use_stall;
    logic [3:0] stall_count;
    logic [1:0] sel0;
    logic [1:0] sel1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign sel0 = fwd_sel[1:0];
    assign sel1 = fwd_sel[3:2];

    rf_forward_scoreboard #(
        .REG_ADDR_W     (5),
        .NUM_RD_PORTS   (2),
        .NUM_FWD_STAGES (3),
        .LOAD_LAT       (1),
        .STALL_CNT_W    (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_opcode      (id_opcode),
        .id_rt          (id_rt),
        .id_rd          (id_rd),
        .id_reg_write   (id_reg_write),
        .id_mem_read    (id_mem_read),
        .id_src_addr    (id_src_addr),
        .id_src_used    (id_src_used),
        .flush          (flush),
        .ext_stall      (ext_stall),
        .fwd_sel        (fwd_sel),
        .load_use_stall (load_use_stall),
        .stall_count    (stall_count)
    );

    // Model: the instructions in EX, MEM, WB (index 0 = EX); only real register writes matter.
    typedef struct packed {
        bit       writes;
        bit [4:0] dst;
        bit       load;
    } slot_t;

    slot_t pipe [3];
    int    m_cnt;

    function automatic void model_eval(output int e0, output int e1, output bit est);
        int sel [2];
        bit haz;
        haz = 1'b0;
        for (int p = 0; p < 2; p++) begin
            int a;
            a = (p == 0) ? int'(id_src_addr[4:0]) : int'(id_src_addr[9:5]);
            sel[p] = 0;
            if (id_src_used[p] && a != 0) begin
                for (int s = 0; s < 3; s++) begin
                    if (pipe[s].writes && int'(pipe[s].dst) == a) begin
                        // A load still in EX has no data yet.
                        if (pipe[s].load && s == 0) haz = 1'b1;
                        else sel[p] = 3 - s;
                        break;
                    end
                end
            end
        end
        e0  = sel[0];
        e1  = sel[1];
        est = id_valid && !flush && haz;
    endfunction

    task automatic tick();
        int  e0, e1;
        bit  est;
        slot_t nw;
        model_eval(e0, e1, est);
        @(posedge clk);
        if (rst) begin
            for (int s = 0; s < 3; s++) pipe[s] = '0;
            m_cnt = 0;
        end else if (!ext_stall) begin
            nw = '0;
            if (id_valid && !flush && !est) begin
                nw.dst    = (id_opcode == 6'h00) ? id_rd : id_rt;
                nw.writes = id_reg_write && nw.dst != 0;
                nw.load   = id_mem_read;
            end
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = nw;
            if (est && m_cnt < 15) m_cnt++;
        end
        #1;
    endtask

    task automatic set_instr(input bit v, input bit rtype, input bit [4:0] dst, input bit rw,
                             input bit ld, input bit [4:0] a0, input bit [4:0] a1,
                             input bit [1:0] used);
        id_valid     = v;
        id_opcode    = rtype ? 6'h00 : (ld ? 6'h23 : 6'h08);
        // The unselected destination field carries junk to exercise the R-type mux.
        id_rd        = rtype ? dst : 5'($urandom);
        id_rt        = rtype ? 5'($urandom) : dst;
        id_reg_write = rw;
        id_mem_read  = ld;
        id_src_addr  = {a1, a0};
        id_src_used  = used;
    endtask

    task automatic idle();
        set_instr(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
        flush     = 1'b0;
        ext_stall = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        set_instr(1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 5'd1, 5'd2, 2'b11);
        flush     = 1'b0;
        ext_stall = 1'b0;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        set_instr(1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 5'd3, 5'd3, 2'b11);
        @(negedge clk);
        n_cmp++; if (sel0 !== 2'd0) begin n_bad++; $display("FAIL reset_sel0: got %0d expected 0", sel0); end
        n_cmp++; if (sel1 !== 2'd0) begin n_bad++; $display("FAIL reset_sel1: got %0d expected 0", sel1); end
        n_cmp++; if (load_use_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %0b expected 0", load_use_stall); end
        n_cmp++; if (stall_count !== 4'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", stall_count); end
    endtask

    task automatic test_alu_raw();
        do_reset();
        set_instr(1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 5'd1, 5'd2, 2'b11);  // add r3,r1,r2
        tick();
        set_instr(1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 5'd3, 5'd3, 2'b11);  // sub r4,r3,r3
        @(negedge clk);
        n_cmp++; if (sel0 !== 2'd3) begin n_bad++; $display("FAIL alu_sel0: got %0d expected 3", sel0); end
        n_cmp++; if (sel1 !== 2'd3) begin n_bad++; $display("FAIL alu_sel1: got %0d expected 3", sel1); end
        n_cmp++; if (load_use_stall !== 1'b0) begin n_bad++; $display("FAIL alu_stall: got %0b expected 0", load_use_stall); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_instr(1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 5'd1, 5'd0, 2'b01);  // lw r5
        tick();
        set_instr(1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 5'd0, 2'b11);  // add r6,r5,r0
        @(negedge clk);
        n_cmp++; if (load_use_stall !== 1'b1) begin n_bad++; $display("FAIL lu_stall1: got %0b expected 1", load_use_stall); end
        n_cmp++; if (sel0 !== 2'd0) begin n_bad++; $display("FAIL lu_sel0_1: got %0d expected 0", sel0); end
        tick();
        @(negedge clk);
        n_cmp++; if (sel0 !== 2'd2) begin n_bad++; $display("FAIL lu_sel0_2: got %0d expected 2", sel0); end
        n_cmp++; if (load_use_stall !== 1'b0) begin n_bad++; $display("FAIL lu_stall2: got %0b expected 0", load_use_stall); end
        n_cmp++; if (stall_count !== 4'd1) begin n_bad++; $display("FAIL lu_count: got %0d expected 1", stall_count); end
    endtask

    task automatic test_priority();
        int exp_sel [4] = '{3, 2, 1, 0};
        // k = number of bubbles following the three producers of r7 (up to all three gone).
        for (int k = 0; k < 4; k++) begin
            do_reset();
            set_instr(1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 5'd1, 5'd0, 2'b01);  // addi r7
            tick();
            set_instr(1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 5'd2, 5'd3, 2'b11);  // or r7
            if (k < 2) tick();
            else begin idle(); tick(); end
            set_instr(1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 5'd2, 5'd3, 2'b11);  // add r7
            if (k < 1) tick();
            else begin idle(); tick(); end
            if (k == 3) begin idle(); tick(); end
            set_instr(1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 5'd7, 5'd7, 2'b11);
            @(negedge clk);
            n_cmp++;
            if (int'(sel0) != exp_sel[k] || $isunknown(sel0)) begin
                n_bad++; $display("FAIL prio_sel0[%0d]: got %0d expected %0d", k, sel0, exp_sel[k]);
            end
            n_cmp++;
            if (int'(sel1) != exp_sel[k] || $isunknown(sel1)) begin
                n_bad++; $display("FAIL prio_sel1[%0d]: got %0d expected %0d", k, sel1, exp_sel[k]);
            end
        end
    endtask

    task automatic test_r0_and_unused();
        do_reset();
        set_instr(1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 5'd1, 5'd0, 2'b01);  // load into r0
        tick();
        set_instr(1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 5'd0, 2'b11);  // reads r0, writes r9
        @(negedge clk);
        n_cmp++; if (sel0 !== 2'd0) begin n_bad++; $display("FAIL r0_sel0: got %0d expected 0", sel0); end
        n_cmp++; if (sel1 !== 2'd0) begin n_bad++; $display("FAIL r0_sel1: got %0d expected 0", sel1); end
        n_cmp++; if (load_use_stall !== 1'b0) begin n_bad++; $display("FAIL r0_stall: got %0b expected 0", load_use_stall); end
        tick();
        set_instr(1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 5'd9, 5'd9, 2'b10);
        @(negedge clk);
        n_cmp++; if (sel0 !== 2'd0) begin n_bad++; $display("FAIL unused_sel0: got %0d expected 0", sel0); end
        n_cmp++; if (sel1 !== 2'd3) begin n_bad++; $display("FAIL used_sel1: got %0d expected 3", sel1); end
    endtask

    task automatic test_ext_stall_flush();
        do_reset();
        set_instr(1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 5'd1, 5'd0, 2'b01);  // lw r5
        tick();
        set_instr(1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 5'd5, 5'd0, 2'b11);  // add r5,r5,r0
        ext_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (load_use_stall !== 1'b1) begin n_bad++; $display("FAIL xs_stall[%0d]: got %0b expected 1", i, load_use_stall); end
            n_cmp++; if (sel0 !== 2'd0) begin n_bad++; $display("FAIL xs_sel0[%0d]: got %0d expected 0", i, sel0); end
            n_cmp++; if (stall_count !== 4'd0) begin n_bad++; $display("FAIL xs_count[%0d]: got %0d expected 0", i, stall_count); end
            tick();
        end
        ext_stall = 1'b0;
        flush     = 1'b1;
        @(negedge clk);
        n_cmp++; if (load_use_stall !== 1'b0) begin n_bad++; $display("FAIL flush_stall: got %0b expected 0", load_use_stall); end
        tick();
        flush = 1'b0;
        set_instr(1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 5'd5, 5'd5, 2'b11);
        @(negedge clk);
        n_cmp++; if (sel0 !== 2'd2) begin n_bad++; $display("FAIL flush_sel0: got %0d expected 2", sel0); end
        n_cmp++; if (load_use_stall !== 1'b0) begin n_bad++; $display("FAIL flush_stall2: got %0b expected 0", load_use_stall); end
        n_cmp++; if (stall_count !== 4'd0) begin n_bad++; $display("FAIL flush_count: got %0d expected 0", stall_count); end
    endtask

    task automatic test_saturate_and_reset();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            set_instr(1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 5'd1, 5'd0, 2'b01);
            tick();
            set_instr(1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 5'd0, 2'b01);
            tick();
            tick();
        end
        @(negedge clk);
        n_cmp++; if (stall_count !== 4'd15) begin n_bad++; $display("FAIL sat_count: got %0d expected 15", stall_count); end
        set_instr(1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 5'd1, 5'd0, 2'b01);
        tick();
        set_instr(1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 5'd5, 2'b11);
        @(negedge clk);
        n_cmp++; if (load_use_stall !== 1'b1) begin n_bad++; $display("FAIL pre_rst_stall: got %0b expected 1", load_use_stall); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (stall_count !== 4'd0) begin n_bad++; $display("FAIL rst_count: got %0d expected 0", stall_count); end
        n_cmp++; if (fwd_sel !== 4'd0) begin n_bad++; $display("FAIL rst_sel: got %0h expected 0", fwd_sel); end
        n_cmp++; if (load_use_stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %0b expected 0", load_use_stall); end
    endtask

    task automatic test_random();
        int e0, e1;
        bit est;
        bit rtype;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst          = ($urandom_range(0, 99) == 0);
            id_valid     = ($urandom_range(0, 99) < 85);
            rtype        = $urandom_range(0, 1) == 1;
            id_opcode    = rtype ? 6'h00 : 6'($urandom_range(1, 63));
            id_rd        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            id_reg_write = $urandom_range(0, 3) != 0;
            id_mem_read  = !rtype && ($urandom_range(0, 2) == 0);
            id_src_addr  = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            id_src_used  = 2'($urandom);
            flush        = ($urandom_range(0, 9) == 0);
            ext_stall    = ($urandom_range(0, 99) < 15);
            @(negedge clk);
            model_eval(e0, e1, est);
            n_cmp++; if (int'(sel0) != e0 || $isunknown(sel0)) begin n_bad++; $display("FAIL rnd_sel0[%0d]: got %0d expected %0d", i, sel0, e0); end
            n_cmp++; if (int'(sel1) != e1 || $isunknown(sel1)) begin n_bad++; $display("FAIL rnd_sel1[%0d]: got %0d expected %0d", i, sel1, e1); end
            n_cmp++; if (load_use_stall !== est) begin n_bad++; $display("FAIL rnd_stall[%0d]: got %0b expected %0b", i, load_use_stall, est); end
            n_cmp++; if (int'(stall_count) != m_cnt || $isunknown(stall_count)) begin n_bad++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", i, stall_count, m_cnt); end
            tick();
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        for (int s = 0; s < 3; s++) pipe[s] = '0;
        m_cnt = 0;
        rst   = 1'b0;
        idle();
        #1;
        test_reset();
        test_alu_raw();
        test_load_use();
        test_priority();
        test_r0_and_unused();
        test_ext_stall_flush();
        test_saturate_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
